// File: rtl/risc_wb_sched_pkg.sv
// Shared widths and the ALU writeback entry type for the writeback scheduler slice.
package risc_pkg;

  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 8;

  typedef struct packed {
    logic [ADDR_W-1:0] dst;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/risc_wb_sched_fifo.sv
// ALU writeback FIFO with per-entry valid/dst taps for hazard compare.
// With RISC_WB_FWD_EN the newest entry is also exported for operand forwarding.
module risc_wb_fifo
  import risc_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             push_i,
  input  wb_entry_t                        push_ent_i,
  input  logic                             pop_i,
  output wb_entry_t                        head_o,
  output logic [CNT_W-1:0]                 count_o,
  output logic [DEPTH-1:0]                 ent_vld_o,
  output logic [DEPTH-1:0][ADDR_W-1:0]     ent_dst_o
`ifdef RISC_WB_FWD_EN
  ,
  output wb_entry_t                        newest_o
`endif
);

  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] off;

  // DEPTH is a power of two, so pointer wrap is the natural overflow.
  always_comb begin
    wr_ptr_d = push_i ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop_i  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push_i && !pop_i) count_d = count_q + 1'b1;
    if (!push_i && pop_i) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_i) mem_q[wr_ptr_q] <= push_ent_i;
    end
  end

  // An entry is live when its distance from the read pointer is below count.
  always_comb begin
    off       = '0;
    ent_vld_o = '0;
    ent_dst_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off          = PTR_W'(i) - rd_ptr_q;
      ent_vld_o[i] = CNT_W'(off) < count_q;
      ent_dst_o[i] = mem_q[i].dst;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
`ifdef RISC_WB_FWD_EN
  assign newest_o = mem_q[wr_ptr_q - 1'b1];
`endif

endmodule

// File: rtl/risc_wb_sched.sv
// Writeback scheduler: shares the register-file write port between load returns
// (always granted) and buffered ALU results; tracks pending loads and flags hazards.
// Optional operand forwarding is enabled with RISC_WB_FWD_EN.
module risc_wb_sched #(
  parameter int DATA_W = risc_pkg::DATA_W,
  parameter int ADDR_W = risc_pkg::ADDR_W,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_vld,
  input  logic [ADDR_W-1:0] alu_dst,
  input  logic [DATA_W-1:0] alu_rslt,
  output logic              alu_rdy,
  input  logic              ld_issue,
  input  logic [ADDR_W-1:0] ld_issue_dst,
  input  logic              ld_vld,
  input  logic [ADDR_W-1:0] ld_dst,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [ADDR_W-1:0] opnda_addr,
  input  logic [ADDR_W-1:0] opndb_addr,
  output logic              haz_a,
  output logic              haz_b,
  output logic              reg_wr_vld,
  output logic              load_op,
  output logic [ADDR_W-1:0] dst,
  output logic [DATA_W-1:0] rslt,
  output logic [DATA_W-1:0] dmdataout,
  output logic              err_unexp
`ifdef RISC_WB_FWD_EN
  ,
  output logic              fwd_a_vld,
  output logic              fwd_b_vld,
  output logic [DATA_W-1:0] fwd_a_data,
  output logic [DATA_W-1:0] fwd_b_data
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  risc_pkg::wb_entry_t               push_ent, head;
  logic [CNT_W-1:0]                  count;
  logic [DEPTH-1:0]                  ent_vld;
  logic [DEPTH-1:0][ADDR_W-1:0]      ent_dst;
  logic                              push, pop;

  logic                              reg_wr_vld_q, reg_wr_vld_d;
  logic                              load_op_q, load_op_d;
  logic [ADDR_W-1:0]                 dst_q, dst_d;
  logic [DATA_W-1:0]                 rslt_q, rslt_d;
  logic [DATA_W-1:0]                 dmdataout_q, dmdataout_d;
  logic [risc_pkg::NUM_REGS-1:0]     pend_q, pend_d;
  logic                              err_q, err_d;

  logic fifo_hit_a, fifo_hit_b, wr_hit_a, wr_hit_b;

  // ALU handshake: a result transfers on a cycle where alu_vld and alu_rdy are both
  // high; alu_rdy depends only on registered count, and upstream holds alu_vld/data
  // stable until the transfer.
  assign alu_rdy  = count < CNT_W'(DEPTH);
  assign push     = alu_vld && alu_rdy;
  assign pop      = !ld_vld && (count != '0);
  assign push_ent = {alu_dst, alu_rslt};

  risc_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push),
    .push_ent_i (push_ent),
    .pop_i      (pop),
    .head_o     (head),
    .count_o    (count),
    .ent_vld_o  (ent_vld),
    .ent_dst_o  (ent_dst)
`ifdef RISC_WB_FWD_EN
    ,
    .newest_o   (newest)
`endif
  );

  // Load returns cannot stall, so they always take the port ahead of the FIFO.
  always_comb begin
    reg_wr_vld_d = 1'b0;
    load_op_d    = load_op_q;
    dst_d        = dst_q;
    rslt_d       = rslt_q;
    dmdataout_d  = dmdataout_q;
    if (ld_vld) begin
      reg_wr_vld_d = 1'b1;
      load_op_d    = 1'b1;
      dst_d        = ld_dst;
      dmdataout_d  = ld_data;
    end else if (pop) begin
      reg_wr_vld_d = 1'b1;
      load_op_d    = 1'b0;
      dst_d        = head.dst;
      rslt_d       = head.data;
    end
  end

  // Issue is applied after return so a same-register set wins over the clear.
  always_comb begin
    pend_d = pend_q;
    if (ld_vld)   pend_d[ld_dst]       = 1'b0;
    if (ld_issue) pend_d[ld_issue_dst] = 1'b1;
    err_d = err_q | (ld_vld & ~pend_q[ld_dst]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_wr_vld_q <= 1'b0;
      load_op_q    <= 1'b0;
      dst_q        <= '0;
      rslt_q       <= '0;
      dmdataout_q  <= '0;
      pend_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      reg_wr_vld_q <= reg_wr_vld_d;
      load_op_q    <= load_op_d;
      dst_q        <= dst_d;
      rslt_q       <= rslt_d;
      dmdataout_q  <= dmdataout_d;
      pend_q       <= pend_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    fifo_hit_a = 1'b0;
    fifo_hit_b = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i] && (ent_dst[i] == opnda_addr)) fifo_hit_a = 1'b1;
      if (ent_vld[i] && (ent_dst[i] == opndb_addr)) fifo_hit_b = 1'b1;
    end
    wr_hit_a = reg_wr_vld_q && (dst_q == opnda_addr);
    wr_hit_b = reg_wr_vld_q && (dst_q == opndb_addr);
  end

`ifdef RISC_WB_FWD_EN
  risc_pkg::wb_entry_t newest;
  logic                new_hit_a, new_hit_b;
  logic [DATA_W-1:0]   wr_data;

  // Youngest producer wins: newest FIFO entry, else the write in flight.
  always_comb begin
    wr_data    = load_op_q ? dmdataout_q : rslt_q;
    new_hit_a  = (count != '0) && (newest.dst == opnda_addr);
    new_hit_b  = (count != '0) && (newest.dst == opndb_addr);
    fwd_a_vld  = !pend_q[opnda_addr] && (new_hit_a || (!fifo_hit_a && wr_hit_a));
    fwd_b_vld  = !pend_q[opndb_addr] && (new_hit_b || (!fifo_hit_b && wr_hit_b));
    fwd_a_data = new_hit_a ? newest.data : wr_data;
    fwd_b_data = new_hit_b ? newest.data : wr_data;
    haz_a      = pend_q[opnda_addr] | ((fifo_hit_a | wr_hit_a) & ~fwd_a_vld);
    haz_b      = pend_q[opndb_addr] | ((fifo_hit_b | wr_hit_b) & ~fwd_b_vld);
  end
`else
  assign haz_a = pend_q[opnda_addr] | fifo_hit_a | wr_hit_a;
  assign haz_b = pend_q[opndb_addr] | fifo_hit_b | wr_hit_b;
`endif

  assign reg_wr_vld = reg_wr_vld_q;
  assign load_op    = load_op_q;
  assign dst        = dst_q;
  assign rslt       = rslt_q;
  assign dmdataout  = dmdataout_q;
  assign err_unexp  = err_q;

endmodule

// File: tb/tb_risc_wb_sched.sv
// Bench for risc_wb_sched: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a queue-based reference model.
module tb_risc_wb_sched;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 2;
  localparam int W     = AW + DW;

  logic          clk, rst_n;
  logic          alu_vld, alu_rdy;
  logic [AW-1:0] alu_dst;
  logic [DW-1:0] alu_rslt;
  logic          ld_issue, ld_vld;
  logic [AW-1:0] ld_issue_dst, ld_dst;
  logic [DW-1:0] ld_data;
  logic [AW-1:0] opnda_addr, opndb_addr;
  logic          haz_a, haz_b, reg_wr_vld, load_op, err_unexp;
  logic [AW-1:0] dst;
  logic [DW-1:0] rslt, dmdataout;
`ifdef RISC_WB_FWD_EN
  logic          fwd_a_vld, fwd_b_vld;
  logic [DW-1:0] fwd_a_data, fwd_b_data;
`endif

  risc_wb_sched #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alu_vld      (alu_vld),
    .alu_dst      (alu_dst),
    .alu_rslt     (alu_rslt),
    .alu_rdy      (alu_rdy),
    .ld_issue     (ld_issue),
    .ld_issue_dst (ld_issue_dst),
    .ld_vld       (ld_vld),
    .ld_dst       (ld_dst),
    .ld_data      (ld_data),
    .opnda_addr   (opnda_addr),
    .opndb_addr   (opndb_addr),
    .haz_a        (haz_a),
    .haz_b        (haz_b),
    .reg_wr_vld   (reg_wr_vld),
    .load_op      (load_op),
    .dst          (dst),
    .rslt         (rslt),
    .dmdataout    (dmdataout),
    .err_unexp    (err_unexp)
`ifdef RISC_WB_FWD_EN
    ,
    .fwd_a_vld    (fwd_a_vld),
    .fwd_b_vld    (fwd_b_vld),
    .fwd_a_data   (fwd_a_data),
    .fwd_b_data   (fwd_b_data)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [W-1:0] exp_q[$];
  logic [7:0]   m_pend = '0;
  logic         m_err = 1'b0, m_wr = 1'b0, m_lop = 1'b0;
  logic [AW-1:0] m_dst = '0;
  logic [DW-1:0] m_rslt = '0, m_dm = '0;

  function automatic logic m_haz(input logic [AW-1:0] a);
    logic h;
    h = m_pend[a] || (m_wr && (m_dst == a));
    for (int i = 0; i < exp_q.size(); i++)
      if (exp_q[i][W-1:DW] == a) h = 1'b1;
    return h;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic         can_push;
    logic [W-1:0] e;
    if (!rst_n) begin
      exp_q.delete();
      m_pend = '0; m_err = 1'b0; m_wr = 1'b0; m_lop = 1'b0;
      m_dst = '0; m_rslt = '0; m_dm = '0;
    end else begin
      can_push = exp_q.size() < DEPTH;
      if (ld_vld) begin
        m_wr = 1'b1; m_lop = 1'b1; m_dst = ld_dst; m_dm = ld_data;
        if (!m_pend[ld_dst]) m_err = 1'b1;
      end else if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        m_wr = 1'b1; m_lop = 1'b0; m_dst = e[W-1:DW]; m_rslt = e[DW-1:0];
      end else begin
        m_wr = 1'b0;
      end
      if (alu_vld && can_push) exp_q.push_back({alu_dst, alu_rslt});
      if (ld_vld)   m_pend[ld_dst] = 1'b0;
      if (ld_issue) m_pend[ld_issue_dst] = 1'b1;
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      chk("reg_wr_vld", reg_wr_vld, m_wr);
      chk("load_op", load_op, m_lop);
      chk("dst", dst, m_dst);
      chk("rslt", rslt, m_rslt);
      chk("dmdataout", dmdataout, m_dm);
      chk("alu_rdy", alu_rdy, exp_q.size() < DEPTH);
      chk("haz_a", haz_a, m_haz(opnda_addr));
      chk("haz_b", haz_b, m_haz(opndb_addr));
      chk("err_unexp", err_unexp, m_err);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_vld = 0; alu_dst = 0; alu_rslt = 0;
    ld_issue = 0; ld_issue_dst = 0; ld_vld = 0; ld_dst = 0; ld_data = 0;
  endtask

  task automatic chk_zero_outs(input string tag);
    chk({tag, "_wr"}, reg_wr_vld, 0);
    chk({tag, "_lop"}, load_op, 0);
    chk({tag, "_dst"}, dst, 0);
    chk({tag, "_rslt"}, rslt, 0);
    chk({tag, "_dm"}, dmdataout, 0);
    chk({tag, "_err"}, err_unexp, 0);
    chk({tag, "_rdy"}, alu_rdy, 1);
    chk({tag, "_haza"}, haz_a, 0);
    chk({tag, "_hazb"}, haz_b, 0);
  endtask

  initial begin
    logic acc;
    int   pl[$];
    idle_inputs();
    opnda_addr = 0; opndb_addr = 0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero_outs("reset");
    rst_n = 1'b1;
    cmp_en = 1'b1;
    tick();

    // ALU push dst=3, 0x5A: write two cycles later
    opnda_addr = 3; alu_vld = 1; alu_dst = 3; alu_rslt = 8'h5A;
    tick();
    alu_vld = 0;
    chk("t1_haz_c1", haz_a, 1); chk("t1_wr_c1", reg_wr_vld, 0);
    tick();
    chk("t1_wr_c2", reg_wr_vld, 1); chk("t1_lop_c2", load_op, 0);
    chk("t1_dst_c2", dst, 3); chk("t1_rslt_c2", rslt, 8'h5A); chk("t1_haz_c2", haz_a, 1);
    tick();
    chk("t1_haz_c3", haz_a, 0); chk("t1_wr_c3", reg_wr_vld, 0);

    // ALU back-pressure while loads hog the port
    for (int i = 0; i < 4; i++) begin
      ld_issue = 1; ld_issue_dst = AW'(i); tick();
    end
    ld_issue = 0;
    opnda_addr = 6;
    ld_vld = 1; ld_dst = 0; ld_data = 8'hA0; alu_vld = 1; alu_dst = 4; alu_rslt = 8'h11;
    tick();
    ld_dst = 1; ld_data = 8'hA1; alu_dst = 5; alu_rslt = 8'h22;
    chk("t2_rdy_c1", alu_rdy, 1);
    tick();
    ld_dst = 2; ld_data = 8'hA2; alu_dst = 6; alu_rslt = 8'h33;
    chk("t2_rdy_c2", alu_rdy, 0);
    tick();
    ld_dst = 3; ld_data = 8'hA3;
    chk("t2_rdy_c3", alu_rdy, 0); chk("t2_dst_c3", dst, 2);
    chk("t2_dm_c3", dmdataout, 8'hA2); chk("t2_haz_c3", haz_a, 0);
    tick();
    ld_vld = 0;
    chk("t2_rdy_c4", alu_rdy, 0); chk("t2_lop_c4", load_op, 1); chk("t2_dst_c4", dst, 3);
    tick();
    chk("t2_rdy_c5", alu_rdy, 1); chk("t2_lop_c5", load_op, 0);
    chk("t2_dst_c5", dst, 4); chk("t2_rslt_c5", rslt, 8'h11); chk("t2_dmhold_c5", dmdataout, 8'hA3);
    tick();
    alu_vld = 0;
    chk("t2_dst_c6", dst, 5); chk("t2_rslt_c6", rslt, 8'h22); chk("t2_haz_c6", haz_a, 1);
    tick();
    chk("t2_dst_c7", dst, 6); chk("t2_rslt_c7", rslt, 8'h33);
    tick();
    chk("t2_wr_c8", reg_wr_vld, 0); chk("t2_rslthold_c8", rslt, 8'h33);

    // Load issue/return on r5
    opndb_addr = 5; ld_issue = 1; ld_issue_dst = 5;
    tick();
    ld_issue = 0;
    for (int c = 1; c <= 3; c++) begin
      chk("t3_haz_wait", haz_b, 1); tick();
    end
    ld_vld = 1; ld_dst = 5; ld_data = 8'hC3;
    chk("t3_haz_c4", haz_b, 1);
    tick();
    ld_vld = 0;
    chk("t3_wr_c5", reg_wr_vld, 1); chk("t3_lop_c5", load_op, 1);
    chk("t3_dst_c5", dst, 5); chk("t3_dm_c5", dmdataout, 8'hC3); chk("t3_haz_c5", haz_b, 1);
    tick();
    chk("t3_haz_c6", haz_b, 0); chk("t3_err_c6", err_unexp, 0);

    // Same-cycle issue and return on r6: pend stays set
    opndb_addr = 6; ld_issue = 1; ld_issue_dst = 6;
    tick();
    ld_vld = 1; ld_dst = 6; ld_data = 8'h66;
    tick();
    ld_issue = 0; ld_vld = 0;
    chk("t6_dst", dst, 6);
    tick();
    chk("t6_haz_pend", haz_b, 1); chk("t6_wr", reg_wr_vld, 0); chk("t6_err", err_unexp, 0);
    ld_vld = 1; ld_dst = 6; ld_data = 8'h77;
    tick();
    ld_vld = 0;
    tick();
    chk("t6_haz_clr", haz_b, 0);

    // Unexpected load to r2, then async reset mid-stream
    ld_vld = 1; ld_dst = 2; ld_data = 8'h99;
    tick();
    ld_vld = 0;
    chk("t5_wr", reg_wr_vld, 1); chk("t5_dst", dst, 2); chk("t5_dm", dmdataout, 8'h99);
    chk("t5_err", err_unexp, 1);
    tick();
    chk("t5_err_sticky", err_unexp, 1);
    alu_vld = 1; alu_dst = 1; alu_rslt = 8'h44; ld_issue = 1; ld_issue_dst = 4;
    tick();
    alu_dst = 7; alu_rslt = 8'h55; ld_issue = 0;
    tick();
    idle_inputs();
    opnda_addr = 4; opndb_addr = 7;
    #2 rst_n = 1'b0;
    #1 chk_zero_outs("midrst");
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("post_rst_wr", reg_wr_vld, 0); chk("post_rst_rdy", alu_rdy, 1);

    // Randomized traffic
    acc = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc == 1500) begin
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        tick();
        acc = 1'b1;
      end
      if (!(alu_vld && !acc)) begin
        alu_vld  = ($urandom_range(0, 99) < 55);
        alu_dst  = AW'($urandom_range(0, 7));
        alu_rslt = DW'($urandom);
      end
      ld_issue     = ($urandom_range(0, 99) < 25);
      ld_issue_dst = AW'($urandom_range(0, 7));
      pl.delete();
      for (int r = 0; r < 8; r++) if (m_pend[r]) pl.push_back(r);
      ld_vld  = 1'b0;
      ld_dst  = AW'($urandom_range(0, 7));
      ld_data = DW'($urandom);
      if (pl.size() > 0 && $urandom_range(0, 99) < 35) begin
        ld_vld = 1'b1;
        ld_dst = AW'(pl[$urandom_range(0, pl.size() - 1)]);
      end else if ($urandom_range(0, 99) < 3) begin
        ld_vld = 1'b1;
      end
      opnda_addr = AW'($urandom_range(0, 7));
      opndb_addr = AW'($urandom_range(0, 7));
      acc = alu_vld && alu_rdy;
      tick();
    end
    idle_inputs();
    repeat (4) tick();
    cmp_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
